// File: rtl/uart_frame_assembler_if.sv
// Byte stream in from the UART receiver, verified cube frame and error status out.
interface uart_frame_assembler_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [511:0] frame_cube_flat;
    logic         frame_valid;
    logic         frame_err;
    logic [15:0]  err_cnt;

    modport master (
        output rx_data,
        output rx_valid,
        input  frame_cube_flat,
        input  frame_valid,
        input  frame_err,
        input  err_cnt
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output frame_cube_flat,
        output frame_valid,
        output frame_err,
        output err_cnt
    );
endinterface

// File: rtl/uart_frame_assembler.sv
// Hunts for HEADER, collects 64 payload bytes, commits the frame only if the checksum byte matches.
// Status pulses appear one cycle after the deciding byte or timeout; no backpressure, one byte per rx_valid.
module uart_frame_assembler #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    uart_frame_assembler_if.slave   bus
);

    localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [7:0]     sum_q, sum_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [511:0]   asm_q, asm_d;
    logic [511:0]   frame_q, frame_d;
    logic           fv_q, fv_d;
    logic           fe_q, fe_d;
    logic [15:0]    err_cnt_q, err_cnt_d;
    logic           tmo_expire;

    // A byte arriving on the expiry cycle takes priority over the abort.
    assign tmo_expire = !bus.rx_valid && (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        tmo_d     = tmo_q;
        asm_d     = asm_q;
        frame_d   = frame_q;
        fv_d      = 1'b0;
        fe_d      = 1'b0;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (bus.rx_valid && bus.rx_data == HEADER) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = 6'd0;
                    sum_d   = 8'd0;
                end
            end

            ST_PAYLOAD: begin
                if (bus.rx_valid) begin
                    asm_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
                    sum_d = sum_q + bus.rx_data;
                    idx_d = idx_q + 6'd1;
                    tmo_d = '0;
                    if (idx_q == 6'd63) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmo_expire) begin
                    fe_d    = 1'b1;
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == sum_q) begin
                        frame_d = asm_q;
                        fv_d    = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else if (tmo_expire) begin
                    fe_d    = 1'b1;
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        endcase

        if (fe_d && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= 6'd0;
            sum_q     <= 8'd0;
            tmo_q     <= '0;
            asm_q     <= '0;
            frame_q   <= '0;
            fv_q      <= 1'b0;
            fe_q      <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            asm_q     <= asm_d;
            frame_q   <= frame_d;
            fv_q      <= fv_d;
            fe_q      <= fe_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.frame_cube_flat = frame_q;
    assign bus.frame_valid     = fv_q;
    assign bus.frame_err       = fe_q;
    assign bus.err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: frame table plus timeout, reset and saturation sequences.
module tb_uart_frame_assembler;

    localparam int T = 20;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    uart_frame_assembler_if bus();

    uart_frame_assembler #(
        .HEADER         (8'hA5),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int         mode;       // 0: k, 1: all A5, 2: 255-k, 3: all 00
        logic [7:0] csum;
        bit         garbage;    // prefix 00 FF 5A before the header
        bit         exp_valid;
        logic [15:0] exp_err;
        logic [7:0] exp_b0;
        logic [7:0] exp_b63;
    } vec_t;

    vec_t tbl [6];

    int n_vec = 0;
    int n_bad = 0;
    int fv_total = 0;
    int fe_total = 0;
    int exp_fv = 0;
    int exp_fe = 0;
    logic [15:0]  exp_err;
    logic [511:0] exp_frame;

    always @(negedge clk) begin
        fv_total += int'(bus.frame_valid);
        fe_total += int'(bus.frame_err);
        if (bus.frame_valid && bus.frame_err) begin
            n_bad++;
            $display("FAIL pulse_overlap: frame_valid=1 frame_err=1 required not both");
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] pay(input int mode, input int k);
        case (mode)
            0:       return 8'(k);
            1:       return 8'hA5;
            2:       return 8'(255 - k);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [511:0] build(input int mode);
        logic [511:0] f;
        f = '0;
        for (int k = 0; k < 64; k++) f[8*k +: 8] = pay(mode, k);
        return f;
    endfunction

    task automatic send_frame(input int mode, input logic [7:0] csum);
        send_byte(8'hA5);
        for (int k = 0; k < 64; k++) send_byte(pay(mode, k));
        send_byte(csum);
    endtask

    task automatic chk_valid_frame(input string tag, input int mode);
        exp_frame = build(mode);
        exp_fv++;
        chk({tag, "_fv"},    512'(bus.frame_valid), 512'(1'b1));
        chk({tag, "_fe"},    512'(bus.frame_err),   512'(1'b0));
        chk({tag, "_frame"}, bus.frame_cube_flat,   exp_frame);
    endtask

    task automatic timeout_abort(input string tag);
        send_byte(8'hA5);
        repeat (T - 1) @(negedge clk);
        chk({tag, "_early"}, 512'(bus.frame_err), 512'(1'b0));
        @(negedge clk);
        exp_fe++;
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        chk({tag, "_fe"},  512'(bus.frame_err), 512'(1'b1));
        chk({tag, "_cnt"}, 512'(bus.err_cnt),   512'(exp_err));
    endtask

    initial begin
        //        mode csum    garb valid err     b0     b63
        tbl[0] = '{0, 8'hE0, 1'b0, 1'b1, 16'd0, 8'h00, 8'h3F};
        tbl[1] = '{0, 8'hE1, 1'b0, 1'b0, 16'd1, 8'h00, 8'h3F};
        tbl[2] = '{2, 8'hE0, 1'b0, 1'b1, 16'd1, 8'hFF, 8'hC0};
        tbl[3] = '{1, 8'h40, 1'b1, 1'b1, 16'd1, 8'hA5, 8'hA5};
        tbl[4] = '{3, 8'h01, 1'b0, 1'b0, 16'd2, 8'hA5, 8'hA5};
        tbl[5] = '{3, 8'h00, 1'b0, 1'b1, 16'd2, 8'h00, 8'h00};

        resetn       = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        exp_err      = 16'd0;
        exp_frame    = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_frame", bus.frame_cube_flat,   512'(0));
        chk("rst_fv",    512'(bus.frame_valid), 512'(0));
        chk("rst_fe",    512'(bus.frame_err),   512'(0));
        chk("rst_cnt",   512'(bus.err_cnt),     512'(0));

        // Frames run back to back: each header follows its predecessor's checksum directly.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].garbage) begin
                send_byte(8'h00);
                send_byte(8'hFF);
                send_byte(8'h5A);
            end
            send_frame(tbl[i].mode, tbl[i].csum);
            if (tbl[i].exp_valid) begin
                exp_frame = build(tbl[i].mode);
                exp_fv++;
            end else begin
                exp_fe++;
            end
            exp_err = tbl[i].exp_err;
            chk($sformatf("v%0d_fv", i),    512'(bus.frame_valid),          512'(tbl[i].exp_valid));
            chk($sformatf("v%0d_fe", i),    512'(bus.frame_err),            512'(!tbl[i].exp_valid));
            chk($sformatf("v%0d_cnt", i),   512'(bus.err_cnt),              512'(tbl[i].exp_err));
            chk($sformatf("v%0d_b0", i),    512'(bus.frame_cube_flat[7:0]), 512'(tbl[i].exp_b0));
            chk($sformatf("v%0d_b63", i),   512'(bus.frame_cube_flat[511:504]), 512'(tbl[i].exp_b63));
            chk($sformatf("v%0d_frame", i), bus.frame_cube_flat,            exp_frame);
        end

        // Timeout after header plus 10 payload bytes.
        send_byte(8'hA5);
        for (int k = 0; k < 10; k++) send_byte(pay(0, k));
        repeat (T - 1) @(negedge clk);
        chk("tmo_early", 512'(bus.frame_err), 512'(0));
        @(negedge clk);
        exp_fe++;
        exp_err = exp_err + 16'd1;
        chk("tmo_fe",    512'(bus.frame_err),  512'(1));
        chk("tmo_cnt",   512'(bus.err_cnt),    512'(exp_err));
        chk("tmo_frame", bus.frame_cube_flat,  exp_frame);
        @(negedge clk);
        chk("tmo_single", 512'(bus.frame_err), 512'(0));
        send_frame(0, 8'hE0);
        chk_valid_frame("tmo_next", 0);

        // Byte landing exactly on the expiry cycle keeps the frame alive.
        send_byte(8'hA5);
        for (int k = 0; k < 10; k++) send_byte(pay(2, k));
        repeat (T - 1) @(negedge clk);
        for (int k = 10; k < 64; k++) send_byte(pay(2, k));
        send_byte(8'hE0);
        chk_valid_frame("edge", 2);
        chk("edge_cnt", 512'(bus.err_cnt), 512'(exp_err));

        // Asynchronous reset in the middle of a frame.
        send_byte(8'hA5);
        for (int k = 0; k < 30; k++) send_byte(pay(1, k));
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_frame", bus.frame_cube_flat,   512'(0));
        chk("arst_fv",    512'(bus.frame_valid), 512'(0));
        chk("arst_fe",    512'(bus.frame_err),   512'(0));
        chk("arst_cnt",   512'(bus.err_cnt),     512'(0));
        @(negedge clk);
        resetn    = 1'b1;
        exp_err   = 16'd0;
        exp_frame = '0;
        @(negedge clk);
        send_frame(2, 8'hE0);
        chk_valid_frame("arst_next", 2);
        chk("arst_next_cnt", 512'(bus.err_cnt), 512'(0));

        // Preload the error counter near its ceiling so saturation is reached quickly.
        dut.err_cnt_q = 16'hFFFC;
        exp_err       = 16'hFFFC;
        for (int i = 0; i < 6; i++) begin
            timeout_abort($sformatf("sat%0d", i));
            @(negedge clk);
        end
        chk("sat_hold", 512'(bus.err_cnt), 512'(16'hFFFF));

        repeat (3) @(negedge clk);
        chk("fv_total", 512'(fv_total), 512'(exp_fv));
        chk("fe_total", 512'(fe_total), 512'(exp_fe));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
